// File: rtl/mux_varredura_canais_if.sv
// Bus bundle for the channel-scan mux: packed samples, mode/selector controls,
// and the registered sample, index, strobes and active-low valve enables.
interface mux_varredura_canais_if #(
  parameter int WIDTH  = 4,
  parameter int CANAIS = 4
);
  localparam int SEL_W = $clog2(CANAIS);

  logic [CANAIS*WIDTH-1:0] inDados;
  logic                    modo;
  logic [SEL_W-1:0]        chave;
  logic                    habilita;
  logic [WIDTH-1:0]        outX;
  logic [SEL_W-1:0]        outCanal;
  logic                    outValido;
  logic [CANAIS-1:0]       outY;
  logic                    fimCiclo;

  modport master (
    output inDados, modo, chave, habilita,
    input  outX, outCanal, outValido, outY, fimCiclo
  );

  modport slave (
    input  inDados, modo, chave, habilita,
    output outX, outCanal, outValido, outY, fimCiclo
  );
endinterface

// File: rtl/mux_varredura_canais.sv
// Registered channel-scan mux: automatic dwell-based scan or manual selection,
// with a captured sample, its channel index, strobes and an active-low valve vector.
module mux_varredura_canais #(
  parameter int WIDTH  = 4,
  parameter int CANAIS = 4,
  parameter int DWELL  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mux_varredura_canais_if.slave   bus
);
  localparam int SEL_W  = $clog2(CANAIS);
  localparam int SEL_W1 = SEL_W + 1;
  localparam int CNT_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0]  IDX_LAST   = SEL_W'(CANAIS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DWELL - 1);
  localparam logic [SEL_W1-1:0] NUM_CANAIS = SEL_W1'(CANAIS);

  typedef enum logic [1:0] {
    PARADO = 2'd0,
    AUTO   = 2'd1,
    MANUAL = 2'd2
  } modo_t;

  function automatic logic [WIDTH-1:0] fatia(input logic [CANAIS*WIDTH-1:0] d,
                                             input logic [SEL_W-1:0] k);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < CANAIS; i++) begin
      r = (SEL_W'(i) == k) ? d[i*WIDTH +: WIDTH] : r;
    end
    return r;
  endfunction

  function automatic logic [CANAIS-1:0] valvulas(input logic [SEL_W-1:0] k);
    logic [CANAIS-1:0] v;
    for (int i = 0; i < CANAIS; i++) begin
      v[i] = (SEL_W'(i) != k);
    end
    return v;
  endfunction

  logic [SEL_W-1:0] idx_r;
  logic [CNT_W-1:0] cnt_r;

  modo_t            modo_s;
  logic [SEL_W-1:0] idx_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [SEL_W-1:0] sel_s;
  logic             captura_s;
  logic             volta_s;
  logic             chave_ok_s;

  // Out-of-range selectors only exist when CANAIS is not a power of two
  generate
    if ((1 << SEL_W) == CANAIS) begin : g_pot
      assign chave_ok_s = 1'b1;
    end else begin : g_npot
      assign chave_ok_s = ({1'b0, bus.chave} < NUM_CANAIS);
    end
  endgenerate

  // Mode decode and next-state/capture decisions for the coming edge
  always_comb begin
    modo_s    = PARADO;
    idx_nxt_s = idx_r;
    cnt_nxt_s = cnt_r;
    sel_s     = idx_r;
    captura_s = 1'b0;
    volta_s   = 1'b0;

    if (!bus.habilita) begin
      modo_s = PARADO;
    end else if (bus.modo) begin
      modo_s = AUTO;
    end else begin
      modo_s = MANUAL;
    end

    case (modo_s)
      AUTO: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt_s = '0;
          captura_s = 1'b1;
          sel_s     = idx_r;
          if (idx_r == IDX_LAST) begin
            idx_nxt_s = '0;
            volta_s   = 1'b1;
          end else begin
            idx_nxt_s = idx_r + SEL_W'(1);
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      MANUAL: begin
        cnt_nxt_s = '0;
        if (chave_ok_s) begin
          idx_nxt_s = bus.chave;
          sel_s     = bus.chave;
          captura_s = 1'b1;
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      default: begin
        idx_nxt_s = idx_r;
        cnt_nxt_s = cnt_r;
      end
    endcase
  end

  // State and all registered outputs; valve vector follows the post-edge index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r         <= '0;
      cnt_r         <= '0;
      bus.outX      <= '0;
      bus.outCanal  <= '0;
      bus.outValido <= 1'b0;
      bus.fimCiclo  <= 1'b0;
      bus.outY      <= '1;
    end else begin
      idx_r         <= idx_nxt_s;
      cnt_r         <= cnt_nxt_s;
      bus.outValido <= captura_s;
      bus.fimCiclo  <= volta_s;
      if (captura_s) begin
        bus.outX     <= fatia(bus.inDados, sel_s);
        bus.outCanal <= sel_s;
      end else begin
        bus.outX     <= bus.outX;
        bus.outCanal <= bus.outCanal;
      end
      if (modo_s == PARADO) begin
        bus.outY <= '1;
      end else begin
        bus.outY <= valvulas(idx_nxt_s);
      end
    end
  end
endmodule

// File: tb/tb_mux_varredura_canais.sv
// Bench for mux_varredura_canais: a 4-channel and a 3-channel instance (DWELL=3)
// checked against a behavioural model every edge, plus table and hand sequences.
module tb_mux_varredura_canais;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mux_varredura_canais_if #(.WIDTH(4), .CANAIS(4)) ifa ();
  mux_varredura_canais_if #(.WIDTH(4), .CANAIS(3)) ifb ();

  mux_varredura_canais #(.WIDTH(4), .CANAIS(4), .DWELL(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  mux_varredura_canais #(.WIDTH(4), .CANAIS(3), .DWELL(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int idx; int cnt; int x; int canal; int val; int fim; int y;
  } mdl_t;

  mdl_t ma, mb;

  // Behavioural reference: channel index and dwell kept as plain integers
  function automatic mdl_t step(mdl_t m, int canais, int dwell, bit rst, bit hab,
                                bit modo, int chave, logic [15:0] d);
    mdl_t r = m;
    int todos = (1 << canais) - 1;
    r.val = 0;
    r.fim = 0;
    if (!rst) begin
      r.idx = 0; r.cnt = 0; r.x = 0; r.canal = 0; r.y = todos;
      return r;
    end
    if (!hab) begin
      r.y = todos;
      return r;
    end
    if (modo) begin
      if (m.cnt == dwell - 1) begin
        r.cnt   = 0;
        r.x     = int'((d >> (4 * m.idx)) & 16'hF);
        r.canal = m.idx;
        r.val   = 1;
        r.idx   = (m.idx + 1) % canais;
        r.fim   = (r.idx == 0) ? 1 : 0;
      end else begin
        r.cnt = m.cnt + 1;
      end
    end else begin
      r.cnt = 0;
      if (chave < canais) begin
        r.idx   = chave;
        r.x     = int'((d >> (4 * chave)) & 16'hF);
        r.canal = chave;
        r.val   = 1;
      end
    end
    r.y = todos & ~(1 << r.idx);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_model();
    chk("a_outX",      32'(ifa.outX),      32'(ma.x));
    chk("a_outCanal",  32'(ifa.outCanal),  32'(ma.canal));
    chk("a_outValido", 32'(ifa.outValido), 32'(ma.val));
    chk("a_fimCiclo",  32'(ifa.fimCiclo),  32'(ma.fim));
    chk("a_outY",      32'(ifa.outY),      32'(ma.y));
    chk("b_outX",      32'(ifb.outX),      32'(mb.x));
    chk("b_outCanal",  32'(ifb.outCanal),  32'(mb.canal));
    chk("b_outValido", 32'(ifb.outValido), 32'(mb.val));
    chk("b_fimCiclo",  32'(ifb.fimCiclo),  32'(mb.fim));
    chk("b_outY",      32'(ifb.outY),      32'(mb.y));
  endtask

  task automatic tick();
    @(posedge clk);
    ma = step(ma, 4, 3, rst_n, ifa.habilita, ifa.modo, int'(ifa.chave), ifa.inDados);
    mb = step(mb, 3, 3, rst_n, ifb.habilita, ifb.modo, int'(ifb.chave), {4'h0, ifb.inDados});
    #1;
    cmp_model();
  endtask

  task automatic drive(input bit hab, input bit modo, input int cha, input int chb);
    ifa.habilita = hab;
    ifa.modo     = modo;
    ifa.chave    = 2'(cha);
    ifb.habilita = hab;
    ifb.modo     = modo;
    ifb.chave    = 2'(chb);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         hab;
    bit         modo;
    int         chave;
    bit         val;
    logic [3:0] x;
    logic [1:0] canal;
    logic [3:0] y;
    bit         fim;
  } vec_t;

  vec_t tbl [16];

  initial begin
    ma = '{0, 0, 0, 0, 0, 0, 15};
    mb = '{0, 0, 0, 0, 0, 0, 7};
    tbl[0]  = '{1'b1, 1'b1, 0, 1'b0, 4'h0, 2'd0, 4'hE, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 0, 1'b0, 4'h0, 2'd0, 4'hE, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 0, 1'b1, 4'hA, 2'd0, 4'hD, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 0, 1'b0, 4'hA, 2'd0, 4'hD, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 0, 1'b0, 4'hA, 2'd0, 4'hD, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 0, 1'b1, 4'hB, 2'd1, 4'hB, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 0, 1'b0, 4'hB, 2'd1, 4'hB, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 0, 1'b0, 4'hB, 2'd1, 4'hB, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 0, 1'b1, 4'hC, 2'd2, 4'h7, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 0, 1'b0, 4'hC, 2'd2, 4'h7, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 0, 1'b0, 4'hC, 2'd2, 4'h7, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 0, 1'b1, 4'hD, 2'd3, 4'hE, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 0, 1'b0, 4'hD, 2'd3, 4'hE, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 2, 1'b1, 4'hC, 2'd2, 4'hB, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 0, 1'b1, 4'hA, 2'd0, 4'hE, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 3, 1'b1, 4'hD, 2'd3, 4'h7, 1'b0};

    ifa.inDados = 16'hDCBA;
    ifb.inDados = 12'hCBA;
    drive(1'b0, 1'b0, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_outY",      32'(ifa.outY),      32'hF);
    chk("rst_outValido", 32'(ifa.outValido), 32'h0);
    chk("rst_outX",      32'(ifa.outX),      32'h0);
    rst_n = 1'b1;

    // Automatic scan of all four channels, then manual stepping
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].hab, tbl[i].modo, tbl[i].chave, tbl[i].chave);
      tick();
      chk($sformatf("tbl%0d_outValido", i), 32'(ifa.outValido), 32'(tbl[i].val));
      chk($sformatf("tbl%0d_outX", i),      32'(ifa.outX),      32'(tbl[i].x));
      chk($sformatf("tbl%0d_outCanal", i),  32'(ifa.outCanal),  32'(tbl[i].canal));
      chk($sformatf("tbl%0d_outY", i),      32'(ifa.outY),      32'(tbl[i].y));
      chk($sformatf("tbl%0d_fimCiclo", i),  32'(ifa.fimCiclo),  32'(tbl[i].fim));
    end

    // Enable dropped mid-dwell: dwell resumes from its frozen count
    do_reset();
    drive(1'b1, 1'b1, 0, 0);
    repeat (4) tick();
    drive(1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("off_outY", 32'(ifa.outY), 32'hF);
      chk("off_outValido", 32'(ifa.outValido), 32'h0);
    end
    drive(1'b1, 1'b1, 0, 0);
    tick();
    chk("reen1_outValido", 32'(ifa.outValido), 32'h0);
    tick();
    chk("reen2_outValido", 32'(ifa.outValido), 32'h1);
    chk("reen2_outX", 32'(ifa.outX), 32'hB);
    chk("reen2_outCanal", 32'(ifa.outCanal), 32'h1);

    // Reset mid-scan on channel 2
    do_reset();
    drive(1'b1, 1'b1, 0, 0);
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_outX", 32'(ifa.outX), 32'h0);
    chk("mrst_outCanal", 32'(ifa.outCanal), 32'h0);
    chk("mrst_outValido", 32'(ifa.outValido), 32'h0);
    chk("mrst_outY", 32'(ifa.outY), 32'hF);
    rst_n = 1'b1;
    tick();
    tick();
    chk("mrst2_outValido", 32'(ifa.outValido), 32'h0);
    tick();
    chk("mrst3_outValido", 32'(ifa.outValido), 32'h1);
    chk("mrst3_outX", 32'(ifa.outX), 32'hA);
    chk("mrst3_outCanal", 32'(ifa.outCanal), 32'h0);

    // AUTO to MANUAL on the would-be capture edge, then back to AUTO
    do_reset();
    drive(1'b1, 1'b1, 1, 1);
    tick();
    tick();
    drive(1'b1, 1'b0, 1, 1);
    tick();
    chk("sw_outX", 32'(ifa.outX), 32'hB);
    chk("sw_outCanal", 32'(ifa.outCanal), 32'h1);
    drive(1'b1, 1'b1, 1, 1);
    tick();
    chk("back1_outValido", 32'(ifa.outValido), 32'h0);
    tick();
    chk("back2_outValido", 32'(ifa.outValido), 32'h0);
    tick();
    chk("back3_outValido", 32'(ifa.outValido), 32'h1);
    chk("back3_outX", 32'(ifa.outX), 32'hB);
    chk("back3_outY", 32'(ifa.outY), 32'hB);

    // Three-channel build: out-of-range selector and wrap from 2 to 0
    do_reset();
    drive(1'b1, 1'b0, 1, 1);
    tick();
    chk("b_man_outX", 32'(ifb.outX), 32'hB);
    drive(1'b1, 1'b0, 3, 3);
    tick();
    chk("b_oor_outValido", 32'(ifb.outValido), 32'h0);
    chk("b_oor_outX", 32'(ifb.outX), 32'hB);
    chk("b_oor_outCanal", 32'(ifb.outCanal), 32'h1);
    chk("b_oor_outY", 32'(ifb.outY), 32'h5);
    drive(1'b1, 1'b1, 0, 0);
    repeat (3) tick();
    chk("b_c1_outCanal", 32'(ifb.outCanal), 32'h1);
    chk("b_c1_fimCiclo", 32'(ifb.fimCiclo), 32'h0);
    repeat (3) tick();
    chk("b_c2_outValido", 32'(ifb.outValido), 32'h1);
    chk("b_c2_outX", 32'(ifb.outX), 32'hC);
    chk("b_c2_fimCiclo", 32'(ifb.fimCiclo), 32'h1);
    chk("b_c2_outY", 32'(ifb.outY), 32'h6);

    // Randomized traffic, model compared every edge
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      drive($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      ifa.inDados = 16'($urandom);
      ifb.inDados = 12'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mux_varredura_canais.md
# mux_varredura_canais

Parametrised, registered successor to the combinational 4-bit 4:1 mux and 1:4 active-low demux used for sensor selection and valve drive in the irrigation controller. It scans CANAIS sensor channels of WIDTH bits each. In automatic mode it dwells a programmable number of cycles per channel; in manual mode it follows a selector. It registers the selected sample and drives an active-low one-hot valve-enable vector for the channel currently selected.

## Interface
- WIDTH, 4: bits per channel sample.
- CANAIS, 4: number of channels; must be ≥2, and need not be a power of two.
- DWELL, 8: cycles spent on each channel in automatic mode; must be ≥1.
- SEL_W, $clog2(CANAIS): selector width (derived; not overridden).
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- inDados  input  CANAIS*WIDTH  packed samples; channel i occupies bits [i*WIDTH +: WIDTH].
- modo  input  1  0 = manual (follow chave), 1 = automatic scan.
- chave  input  SEL_W  manual channel selector.
- habilita  input  1  global enable; 0 freezes scanning and closes all valves.
- outX  output  WIDTH  registered sample of the captured channel.
- outCanal  output  SEL_W  index of the channel held in outX.
- outValido  output  1  one-cycle strobe: outX/outCanal were updated this cycle.
- outY  output  CANAIS  active-low one-hot valve enable for the current channel index.
- fimCiclo  output  1  one-cycle strobe: automatic scan wrapped from CANAIS-1 to 0.

## Operation
- Internal state:
  - idx (SEL_W bits): the current channel index.
  - cnt: the dwell counter, counting 0..DWELL-1.
- FSM states:
  - PARADO: entered when habilita=0.
  - AUTO: entered when habilita=1 and modo=1.
  - MANUAL: entered when habilita=1 and modo=0.
- The state is re-evaluated every cycle from habilita and modo.
- PARADO:
  - idx, cnt, outX and outCanal hold their values.
  - outValido=0, fimCiclo=0, outY all ones.
- AUTO:
  - Each cycle, cnt increments.
  - When cnt==DWELL-1:
    - outX←slice[idx], outCanal←idx, outValido←1 for one cycle.
    - cnt←0.
    - idx←idx+1, wrapping from CANAIS-1 to 0.
    - fimCiclo←1 only on that wrap.
- MANUAL:
  - Every cycle, if chave<CANAIS: idx←chave, outX←slice[chave], outCanal←chave, outValido←1.
  - If chave≥CANAIS (possible only when CANAIS is not a power of two): idx, outX and outCanal hold, and outValido=0.
  - cnt←0. fimCiclo=0.
- outY:
  - When habilita=1, bit idx is 0 and all other bits are 1.
  - When habilita=0, all bits are 1.
  - outY is registered with idx, so it reflects the post-edge idx.
- Mode switch AUTO→MANUAL: the pending dwell is abandoned with no capture; MANUAL rules apply on the next edge.
- Mode switch MANUAL→AUTO: scanning resumes from the current idx with cnt=0, so a full DWELL cycles elapse before the first capture.
- habilita 1→0→1 in AUTO: idx and cnt resume from their frozen values; the dwell count is not restarted.
- All selection arithmetic is unsigned. outX is a pure copy of the slice, with no width change.

## Timing
- Reset values (rst_n=0 sampled on an edge):
  - idx=0, cnt=0, outX=0, outCanal=0, outValido=0, fimCiclo=0, outY all ones.
- Reset has priority over all other inputs.
- Reset asserted mid-dwell or mid-scan discards progress; the next scan starts at channel 0.
- AUTO capture latency: the first capture is visible exactly DWELL edges after the first edge with habilita=1, modo=1 and rst_n=1. Captures then recur every DWELL cycles.
- With DWELL=1, AUTO captures on every edge, and outValido stays high continuously.
- MANUAL latency: 1 cycle from chave to outX, outCanal and outY.
- inDados is sampled only on capture edges.
- Strobes:
  - outValido and fimCiclo are registered.
  - fimCiclo coincides with the outValido strobe of the channel CANAIS-1 capture.
- Every output is registered; there are no combinational input-to-output paths.

## Test plan
All scenarios use WIDTH=4, CANAIS=4, DWELL=3, and inDados = {4'hD, 4'hC, 4'hB, 4'hA} (channel 3 down to channel 0).
- Reset, then habilita=1, modo=1 → outValido pulses on edges 3, 6, 9, 12 with outX = A, B, C, D and outCanal = 0, 1, 2, 3; fimCiclo pulses only on edge 12; outY steps 1110→1101→1011→0111→1110.
- modo=0, chave stepping 2, 0, 3 on consecutive edges → one cycle later outX = C, A, D, outValido held at 1, and outY = 1011, 1110, 0111.
- In AUTO, drop habilita after edge 4 for 5 cycles, then raise it → outY=1111 and outValido=0 while low; the channel 1 capture occurs 2 edges after re-enable.
- In AUTO, assert rst_n=0 for one edge at cnt=1 on channel 2 → all outputs return to reset values; after release, the first capture is outX=A, outCanal=0, 3 edges later.
- Switch AUTO→MANUAL at cnt=2 with chave=1 → no AUTO capture occurs on that edge; outX=B on the next edge. Switch back to AUTO → the next capture is of channel 1, 3 edges later.
- Build with CANAIS=3 and drive chave=3 in MANUAL → outX and outCanal hold and outValido=0. Build with CANAIS=3 in AUTO → idx wraps 2→0, and fimCiclo pulses with the channel 2 capture.
